// File: rtl/hex_digit_scanner.sv
// Time-multiplexed hex digit scanner: one nibble at a time on nibble_out, one-hot digit_en with
// an optional blanking gap per digit; new values are swapped in only at frame boundaries.
module hex_digit_scanner #(
  parameter int NUM_DIGITS   = 4,
  parameter int PRESCALE     = 1024,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic                    load,
  input  logic                    lz_en,
  output logic [3:0]              nibble_out,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    load_ack,
  output logic                    frame_start
);

  localparam int VAL_W   = 4 * NUM_DIGITS;
  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX <= 1) ? 1 : $clog2(CNT_MAX);

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  localparam state_t ST_INIT = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
  localparam state_t ST_POST_SHOW = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [VAL_W-1:0]  display_q, display_d;
  logic [VAL_W-1:0]  shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic              boundary;
  logic              ack_d;
  logic [3:0]        nibble_d;
  logic [NUM_DIGITS-1:0] en_d;

  // upper_zero[i]: nibble i and every more significant nibble of the next display value are zero
  logic [NUM_DIGITS:1] upper_zero;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q + CNT_W'(1);
    boundary  = 1'b0;
    display_d = display_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    ack_d     = 1'b0;

    if (state_q == ST_BLANK) begin
      if (cnt_q == BLANK_LAST) begin
        state_d = ST_SHOW;
        cnt_d   = '0;
      end
    end else begin
      if (cnt_q == SHOW_LAST) begin
        state_d = ST_POST_SHOW;
        cnt_d   = '0;
        if (idx_q == IDX_LAST) begin
          idx_d    = '0;
          boundary = 1'b1;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
    end

    // A load on the boundary cycle bypasses the shadow so it shows in the very next frame
    if (boundary) begin
      if (load) begin
        display_d = value_in;
        ack_d     = 1'b1;
      end else if (pending_q) begin
        display_d = shadow_q;
        ack_d     = 1'b1;
      end
      pending_d = 1'b0;
    end else if (load) begin
      shadow_d  = value_in;
      pending_d = 1'b1;
    end
  end

  assign upper_zero[NUM_DIGITS] = 1'b1;

  generate
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_upper_zero
      assign upper_zero[gi] = (display_d[4*gi +: 4] == 4'h0) && upper_zero[gi+1];
    end
  endgenerate

  // Outputs are computed from next state so the registered values line up with the live state
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_en
      if (gi == 0) begin : g_lsd
        assign en_d[gi] = (state_d == ST_SHOW) && (idx_d == IDX_W'(gi));
      end else begin : g_upper
        assign en_d[gi] = (state_d == ST_SHOW) && (idx_d == IDX_W'(gi)) &&
                          !(lz_en && upper_zero[gi]);
      end
    end
  endgenerate

  always_comb begin
    nibble_d = 4'h0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nibble_d = display_d[4*i +: 4];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_INIT;
      idx_q       <= '0;
      cnt_q       <= '0;
      display_q   <= '0;
      shadow_q    <= '0;
      pending_q   <= 1'b0;
      nibble_out  <= 4'h0;
      digit_en    <= '0;
      load_ack    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      display_q   <= display_d;
      shadow_q    <= shadow_d;
      pending_q   <= pending_d;
      nibble_out  <= nibble_d;
      digit_en    <= en_d;
      load_ack    <= ack_d;
      frame_start <= boundary;
    end
  end

endmodule

// File: tb/tb_hex_digit_scanner.sv
// Directed plus randomized bench for hex_digit_scanner; expected outputs come from a frame-position
// model (cycle count since reset -> frame, digit, phase) rather than from a state machine.
module tb_hex_digit_scanner;

  localparam int N = 4;
  localparam int P = 4;
  localparam int B = 2;
  localparam int SLOT = B + P;
  localparam int L = N * SLOT;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   value_in;
  logic          load;
  logic          lz_en;
  logic [3:0]    nibble_out;
  logic [N-1:0]  digit_en;
  logic          load_ack;
  logic          frame_start;

  int total = 0;
  int bad   = 0;

  // Model state
  int          c;
  logic [15:0] m_disp, m_shadow;
  logic        m_pend, m_ackf, m_lz;

  hex_digit_scanner #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
    .clk(clk), .reset(reset), .value_in(value_in), .load(load), .lz_en(lz_en),
    .nibble_out(nibble_out), .digit_en(digit_en), .load_ack(load_ack), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int pos, d, ph;
    logic [3:0] e_nib;
    logic [N-1:0] e_en;
    logic e_fs, e_ack;
    e_nib = 4'h0; e_en = '0; e_fs = 1'b0; e_ack = 1'b0;
    if (c > 0) begin
      pos   = c % L;
      d     = pos / SLOT;
      ph    = pos % SLOT;
      e_nib = 4'((m_disp >> (4*d)) & 16'hF);
      if (ph >= B && !(m_lz && d > 0 && (m_disp >> (4*d)) == 16'h0))
        e_en = N'(1 << d);
      e_fs  = (pos == 0);
      e_ack = e_fs && m_ackf;
    end
    chk("nibble_out", 32'(nibble_out), 32'(e_nib));
    chk("digit_en", 32'(digit_en), 32'(e_en));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("load_ack", 32'(load_ack), 32'(e_ack));
    $display("cyc=%0d rst=%0b ld=%0b val=%h lz=%0b | nib=%h en=%b fs=%0b ack=%0b",
             c, reset, load, value_in, lz_en, nibble_out, digit_en, frame_start, load_ack);
  endtask

  task automatic step();
    logic r_s, ld_s, lz_s;
    logic [15:0] v_s;
    r_s = reset; ld_s = load; lz_s = lz_en; v_s = value_in;
    @(posedge clk);
    if (r_s) begin
      c = 0; m_disp = 16'h0; m_shadow = 16'h0; m_pend = 1'b0; m_ackf = 1'b0; m_lz = 1'b0;
    end else begin
      if (c % L == L - 1) begin
        if (ld_s) begin
          m_disp = v_s; m_ackf = 1'b1;
        end else if (m_pend) begin
          m_disp = m_shadow; m_ackf = 1'b1;
        end else begin
          m_ackf = 1'b0;
        end
        m_pend = 1'b0;
      end else if (ld_s) begin
        m_shadow = v_s; m_pend = 1'b1;
      end
      c++;
      m_lz = lz_s;
    end
    #1;
    check_outputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Advance until the currently observed cycle sits at frame position tgt
  task automatic run_to(input int tgt);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < L + 2; i++) begin
      if (c > 0 && (c % L) == tgt) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    total++;
    assert (hit) else begin
      bad++;
      $error("FAIL run_to_timeout observed=%0d expected=%0d", c % L, tgt);
    end
  endtask

  task automatic do_load(input logic [15:0] v);
    value_in = v; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; value_in = 16'h0; load = 1'b0; lz_en = 1'b0;
    c = 0; m_disp = 0; m_shadow = 0; m_pend = 0; m_ackf = 0; m_lz = 0;
    run(3);
    reset = 1'b0;

    // Timing with all-zero value, lz off: 1,2,4,8 enables per frame
    run(2 * L + 1);

    // Tear-free load into a frame displaying 0xABCD
    run_to(10); do_load(16'hABCD);
    run_to(5);  do_load(16'h1234);
    run(2 * L);

    // Latest wins
    run_to(3);  do_load(16'h1111);
    run_to(10); do_load(16'h2222);
    run(2 * L);

    // Boundary bypass
    run_to(L - 1); do_load(16'h5A5A);
    run(L + 2);

    // Leading-zero suppression
    lz_en = 1'b1;
    run_to(7); do_load(16'h0050);
    run(2 * L);
    run_to(7); do_load(16'h0000);
    run(2 * L);
    lz_en = 1'b0;
    run(2 * L);

    // Reset mid-SHOW of digit 2
    run_to(2 * SLOT + B + 1);
    do_load(16'hBEEF);
    reset = 1'b1;
    step();
    reset = 1'b0;
    run(2 * L + 2);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      load     = ($urandom % 8) == 0;
      value_in = (($urandom % 3) == 0) ? 16'($urandom % 256) : 16'($urandom);
      if (($urandom % 40) == 0) lz_en = ~lz_en;
      reset    = ($urandom % 400) == 0;
      step();
    end
    reset = 1'b0; load = 1'b0;
    run(L);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
